// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the multicycle CPU controller and datapath.
package cpu_pkg;
    typedef enum logic [3:0] {
        S_INSTRUCTION_FETCH    = 4'd0,
        S_REGISTER_FETCH       = 4'd1,
        S_IMMEDIATE_INJECTION3 = 4'd2,
        S_ALU_R3               = 4'd3,
        S_ALU_RI3              = 4'd4,
        S_ALU4                 = 4'd5,
        S_BRANCH3              = 4'd6,
        S_MEMORY_REF3          = 4'd7,
        S_LOAD4                = 4'd8,
        S_STORE4               = 4'd9,
        S_LOAD5                = 4'd10,
        S_JUMP3                = 4'd11
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03, OP_XOR  = 6'h04, OP_SLT  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SUBI = 6'h09, OP_ANDI = 6'h0A;
    localparam logic [5:0] OP_ORI  = 6'h0B, OP_XORI = 6'h0C, OP_SLTI = 6'h0D;
    localparam logic [5:0] OP_LDI  = 6'h10, OP_LD   = 6'h20, OP_STR  = 6'h21;
    localparam logic [5:0] OP_BEQ  = 6'h30, OP_JUMP = 6'h38;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5;

    localparam logic [1:0] WD_ALUOUT = 2'b00, WD_MDR = 2'b01, WD_IMM = 2'b10;
    localparam logic [1:0] SRCB_REGB = 2'b00, SRCB_ONE = 2'b01, SRCB_IMM = 2'b10, SRCB_BROFF = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_get_data;
        logic       mem_read;
        logic [1:0] reg_wdata_sel;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
        logic       reg_track_sel;
    } ctrl_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps the opcode's low three bits to an ALU operation.
module alu_op_decode
    import cpu_pkg::*;
(
    input  logic [2:0] op_low_i,
    output logic [3:0] alu_op_o
);
    always_comb alu_op_o = (op_low_i > 3'd5) ? ALU_ADD : {1'b0, op_low_i};
endmodule

// File: rtl/control_decode.sv
// control_decode: registered state/opcode to datapath control decoder.
module control_decode
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       memGetData,
    output logic       memRead,
    output logic [1:0] regWriteDataSelect,
    output logic       irWrite,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluOP,
    output logic [1:0] pcSrc,
    output logic       regTrackSelect
);
    ctrl_t      ctrl_d, ctrl_q;
    logic [3:0] op_alu;
    logic       unused_opcode_hi;

    assign unused_opcode_hi = ^opcode[5:4];

    alu_op_decode u_alu_op_decode (
        .op_low_i (opcode[2:0]),
        .alu_op_o (op_alu)
    );

    always_comb begin
        ctrl_d = '0;
        case (state_e'(state))
            S_INSTRUCTION_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.alu_src_b = SRCB_ONE;
                ctrl_d.pc_src    = PC_ALU;
                ctrl_d.pc_write  = 1'b1;
            end
            S_REGISTER_FETCH: ctrl_d.alu_src_b = SRCB_BROFF;
            S_IMMEDIATE_INJECTION3: begin
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.reg_wdata_sel = WD_IMM;
                ctrl_d.reg_track_sel = 1'b1;
            end
            S_ALU_R3: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_REGB;
                ctrl_d.alu_op    = op_alu;
            end
            S_ALU_RI3: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_op    = op_alu;
            end
            // opcode[3] separates I-type (rt destination) from R-type (rd)
            S_ALU4: begin
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.reg_wdata_sel = WD_ALUOUT;
                ctrl_d.reg_track_sel = opcode[3];
            end
            S_BRANCH3: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_src_b     = SRCB_REGB;
                ctrl_d.alu_op        = ALU_SUB;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_src        = PC_ALUOUT;
            end
            S_MEMORY_REF3: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
            end
            S_LOAD4: begin
                ctrl_d.mem_get_data = 1'b1;
                ctrl_d.mem_read     = 1'b1;
            end
            S_STORE4: ctrl_d.mem_get_data = 1'b1;
            S_LOAD5: begin
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.reg_wdata_sel = WD_MDR;
                ctrl_d.reg_track_sel = 1'b1;
            end
            S_JUMP3: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = PC_JUMP;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_q <= '0;
        else        ctrl_q <= ctrl_d;
    end

    assign pcWrite            = ctrl_q.pc_write;
    assign pcWriteCond        = ctrl_q.pc_write_cond;
    assign memGetData         = ctrl_q.mem_get_data;
    assign memRead            = ctrl_q.mem_read;
    assign regWriteDataSelect = ctrl_q.reg_wdata_sel;
    assign irWrite            = ctrl_q.ir_write;
    assign regWrite           = ctrl_q.reg_write;
    assign aluSrcA            = ctrl_q.alu_src_a;
    assign aluSrcB            = ctrl_q.alu_src_b;
    assign aluOP              = ctrl_q.alu_op;
    assign pcSrc              = ctrl_q.pc_src;
    assign regTrackSelect     = ctrl_q.reg_track_sel;
endmodule

// File: tb/tb_control_decode.sv
// tb_control_decode: directed-vector checks of control_decode outputs.
module tb_control_decode;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] state = 4'd0;
    logic [5:0] opcode = 6'd0;
    logic       pcWrite, pcWriteCond, memGetData, memRead, irWrite, regWrite, aluSrcA, regTrackSelect;
    logic [1:0] regWriteDataSelect, aluSrcB, pcSrc;
    logic [3:0] aluOP;
    logic [17:0] obs;
    int n_checks = 0;
    int n_fail = 0;

    control_decode dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .state              (state),
        .opcode             (opcode),
        .pcWrite            (pcWrite),
        .pcWriteCond        (pcWriteCond),
        .memGetData         (memGetData),
        .memRead            (memRead),
        .regWriteDataSelect (regWriteDataSelect),
        .irWrite            (irWrite),
        .regWrite           (regWrite),
        .aluSrcA            (aluSrcA),
        .aluSrcB            (aluSrcB),
        .aluOP              (aluOP),
        .pcSrc              (pcSrc),
        .regTrackSelect     (regTrackSelect)
    );

    always #5 clk = ~clk;

    assign obs = {pcWrite, pcWriteCond, memGetData, memRead, regWriteDataSelect, irWrite,
                  regWrite, aluSrcA, aluSrcB, aluOP, pcSrc, regTrackSelect};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic pw, input logic pwc, input logic mgd, input logic mr,
                                       input logic [1:0] wds, input logic ir, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [3:0] op, input logic [1:0] ps,
                                       input logic rts);
        return {pw, pwc, mgd, mr, wds, ir, rw, asa, asb, op, ps, rts};
    endfunction

    task automatic drive(input logic [3:0] s, input logic [5:0] o);
        @(negedge clk);
        state  = s;
        opcode = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("reset_hold", obs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_first_edge", obs, 0);
        @(posedge clk);
        #1;
        check("if_first", obs, mk(1,0,0,1,2'd0,1,0,0,2'd1,4'd0,2'd0,0));
        drive(4'd3, 6'h01);
        check("alu_r3_sub", obs, mk(0,0,0,0,2'd0,0,0,1,2'd0,4'd1,2'd0,0));
        @(negedge clk);
        state  = 4'd5;
        opcode = 6'h01;
        #1;
        check("latency_hold", obs, mk(0,0,0,0,2'd0,0,0,1,2'd0,4'd1,2'd0,0));
        @(posedge clk);
        #1;
        check("alu4_rtype", obs, mk(0,0,0,0,2'd0,0,1,0,2'd0,4'd0,2'd0,0));
        drive(4'd3, 6'h05);
        check("alu_r3_slt", obs, mk(0,0,0,0,2'd0,0,0,1,2'd0,4'd5,2'd0,0));
        drive(4'd3, 6'h04);
        check("alu_r3_xor", obs, mk(0,0,0,0,2'd0,0,0,1,2'd0,4'd4,2'd0,0));
        drive(4'd3, 6'h06);
        check("alu_r3_low6", obs, mk(0,0,0,0,2'd0,0,0,1,2'd0,4'd0,2'd0,0));
        drive(4'd3, 6'h3F);
        check("alu_r3_low7", obs, mk(0,0,0,0,2'd0,0,0,1,2'd0,4'd0,2'd0,0));
        drive(4'd3, 6'h02);
        check("alu_r3_and", obs, mk(0,0,0,0,2'd0,0,0,1,2'd0,4'd2,2'd0,0));
        drive(4'd4, 6'h08);
        check("alu_ri3_addi", obs, mk(0,0,0,0,2'd0,0,0,1,2'd2,4'd0,2'd0,0));
        drive(4'd5, 6'h08);
        check("alu4_itype", obs, mk(0,0,0,0,2'd0,0,1,0,2'd0,4'd0,2'd0,1));
        drive(4'd4, 6'h0D);
        check("alu_ri3_slti", obs, mk(0,0,0,0,2'd0,0,0,1,2'd2,4'd5,2'd0,0));
        drive(4'd4, 6'h0B);
        check("alu_ri3_ori", obs, mk(0,0,0,0,2'd0,0,0,1,2'd2,4'd3,2'd0,0));
        drive(4'd6, 6'h30);
        check("branch3", obs, mk(0,1,0,0,2'd0,0,0,1,2'd0,4'd1,2'd1,0));
        drive(4'd6, 6'h03);
        check("branch3_opc_ign", obs, mk(0,1,0,0,2'd0,0,0,1,2'd0,4'd1,2'd1,0));
        drive(4'd7, 6'h20);
        check("memref3", obs, mk(0,0,0,0,2'd0,0,0,1,2'd2,4'd0,2'd0,0));
        drive(4'd7, 6'h05);
        check("memref3_opc_ign", obs, mk(0,0,0,0,2'd0,0,0,1,2'd2,4'd0,2'd0,0));
        drive(4'd8, 6'h20);
        check("load4", obs, mk(0,0,1,1,2'd0,0,0,0,2'd0,4'd0,2'd0,0));
        drive(4'd10, 6'h20);
        check("load5", obs, mk(0,0,0,0,2'd1,0,1,0,2'd0,4'd0,2'd0,1));
        drive(4'd9, 6'h21);
        check("store4", obs, mk(0,0,1,0,2'd0,0,0,0,2'd0,4'd0,2'd0,0));
        drive(4'd11, 6'h38);
        check("jump3", obs, mk(1,0,0,0,2'd0,0,0,0,2'd0,4'd0,2'd2,0));
        drive(4'd1, 6'h00);
        check("reg_fetch", obs, mk(0,0,0,0,2'd0,0,0,0,2'd3,4'd0,2'd0,0));
        for (int s = 12; s < 16; s++) begin
            drive(4'(s), 6'h05);
            check($sformatf("unused_state_%0d", s), obs, 0);
        end
        drive(4'd2, 6'h10);
        check("imm_inject3", obs, mk(0,0,0,0,2'd2,0,1,0,2'd0,4'd0,2'd0,1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", obs, 0);
        @(posedge clk);
        #1;
        check("reset_edge_hold", obs, 0);
        @(negedge clk);
        state  = 4'd0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("if_after_reset", obs, mk(1,0,0,1,2'd0,1,0,0,2'd1,4'd0,2'd0,0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
